// File: rtl/snake_pkg.sv
// Shared types and constants for the IR-driven snake direction path.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam logic [7:0] CMD_UP    = 8'h6A;
    localparam logic [7:0] CMD_DOWN  = 8'hEA;
    localparam logic [7:0] CMD_LEFT  = 8'h1A;
    localparam logic [7:0] CMD_RIGHT = 8'h9A;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StCheck = 2'd1;
    localparam logic [1:0] StPush  = 2'd2;

    // Returns {hit, direction}; hit is 0 for any key outside the arrow set.
    function automatic logic [2:0] map_cmd(input logic [7:0] cmd);
        unique case (cmd)
            CMD_UP:    map_cmd = {1'b1, DIR_UP};
            CMD_DOWN:  map_cmd = {1'b1, DIR_DOWN};
            CMD_LEFT:  map_cmd = {1'b1, DIR_LEFT};
            CMD_RIGHT: map_cmd = {1'b1, DIR_RIGHT};
            default:   map_cmd = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/dir_fifo.sv
// Two-entry first-word-fall-through FIFO; pushes are judged against pre-pop occupancy.
module dir_fifo #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   cnt_q;
    logic         do_push;
    logic         do_pop;

    assign full    = (cnt_q == 2'd2);
    assign empty   = (cnt_q == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/ir_dir_ctrl.sv
// NEC frame / repeat validation, arrow-key mapping, reversal filter and repeat pacing
// feeding a small direction queue for the game FSM.
module ir_dir_ctrl
    import snake_pkg::*;
#(
    parameter logic [7:0]  ADDR          = 8'h20,
    parameter int unsigned REPEAT_WINDOW = 2048,
    parameter int unsigned REPEAT_DIV    = 4,
    parameter int unsigned TW            = 11
) (
    input  logic        nec_clk,
    input  logic        reset,
    input  logic [31:0] frame,
    input  logic        frame_valid,
    input  logic        repeat_valid,
    output dir_t        dir,
    output logic        dir_valid,
    input  logic        dir_ready,
    output logic [7:0]  err_cnt,
    output logic        overflow
);

    localparam int unsigned RCW = $clog2(REPEAT_DIV) + 1;

    logic [1:0]     state_q;
    logic [31:0]    frame_q;
    dir_t           cmd_q;
    dir_t           last_dir_q;
    dir_t           last_cmd_q;
    logic           last_cmd_vld_q;
    logic [TW-1:0]  timer_q;
    logic [RCW-1:0] rep_cnt_q;
    logic [7:0]     err_cnt_q;
    logic           overflow_q;

    logic [2:0]     map;
    logic           frame_good;
    logic           good_load;
    logic           rep_accept;
    logic           rep_push;
    logic           is_rev;
    logic           fifo_push;
    logic           fifo_full;
    logic           fifo_empty;
    logic [1:0]     fifo_rdata;

    always_comb begin
        map        = map_cmd(frame_q[15:8]);
        frame_good = (frame_q[31:24] == ADDR) && (frame_q[23:16] == ~ADDR) &&
                     (frame_q[7:0] == ~frame_q[15:8]) && map[2];
        good_load  = (state_q == StCheck) && frame_good;
        // A frame in the same cycle always takes precedence over a repeat.
        rep_accept = (state_q == StIdle) && !frame_valid && repeat_valid &&
                     last_cmd_vld_q && (32'(timer_q) < REPEAT_WINDOW);
        rep_push   = rep_accept && (rep_cnt_q == RCW'(REPEAT_DIV - 1));
        is_rev     = (cmd_q == dir_t'(last_dir_q ^ 2'b01));
        fifo_push  = (state_q == StPush) && !is_rev && !fifo_full;
    end

    always_ff @(posedge nec_clk) begin
        if (reset) begin
            state_q    <= StIdle;
            frame_q    <= '0;
            cmd_q      <= DIR_UP;
            last_dir_q <= DIR_RIGHT;
            last_cmd_q <= DIR_UP;
            rep_cnt_q  <= '0;
            err_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (frame_valid) begin
                        frame_q <= frame;
                        state_q <= StCheck;
                    end else if (rep_accept) begin
                        if (rep_push) begin
                            rep_cnt_q <= '0;
                            cmd_q     <= last_cmd_q;
                            state_q   <= StPush;
                        end else begin
                            rep_cnt_q <= rep_cnt_q + 1'b1;
                        end
                    end
                end
                StCheck: begin
                    if (frame_good) begin
                        cmd_q      <= dir_t'(map[1:0]);
                        last_cmd_q <= dir_t'(map[1:0]);
                        rep_cnt_q  <= '0;
                        state_q    <= StPush;
                    end else begin
                        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                        state_q <= StIdle;
                    end
                end
                StPush: begin
                    if (!is_rev) begin
                        if (fifo_full) overflow_q <= 1'b1;
                        else           last_dir_q <= cmd_q;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Repeat window: restarted by any accepted frame or repeat, expires after REPEAT_WINDOW.
    always_ff @(posedge nec_clk) begin
        if (reset) begin
            last_cmd_vld_q <= 1'b0;
            timer_q        <= '0;
        end else if (good_load) begin
            last_cmd_vld_q <= 1'b1;
            timer_q        <= '0;
        end else if (rep_accept) begin
            timer_q <= '0;
        end else if (last_cmd_vld_q) begin
            if (timer_q == TW'(REPEAT_WINDOW - 1)) begin
                last_cmd_vld_q <= 1'b0;
                timer_q        <= '0;
            end else begin
                timer_q <= timer_q + 1'b1;
            end
        end
    end

    dir_fifo #(
        .W (2)
    ) u_fifo (
        .clk   (nec_clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (cmd_q),
        .pop   (dir_valid && dir_ready),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign dir       = dir_t'(fifo_rdata);
    assign dir_valid = !fifo_empty;
    assign err_cnt   = err_cnt_q;
    assign overflow  = overflow_q;

endmodule
